// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master single-port dbus arbiter with bounded lock and registered read return.
// Define DBUS_ARB_RR_EN for round-robin contention; otherwise master 0 has fixed priority.
module dbus_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_din,
    output logic          bus_we,
    input  logic [DW-1:0] bus_dout
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_gnt_q, rv0_q, rv1_q;
    logic          hold_ok, keep0, keep1, pick1, acc_lock;

`ifdef DBUS_ARB_RR_EN
    assign pick1 = !last_gnt_q;
`else
    assign pick1 = 1'b0;
`endif

    always_comb begin
        hold_ok  = hold_q < HW'(MAX_HOLD);
        keep0    = state_q == OWN0 && m0_req && (!m1_req || hold_ok);
        keep1    = state_q == OWN1 && m1_req && (!m0_req || hold_ok);
        // Without a keeping owner, contention goes to the other master on lock expiry, else to policy
        m0_gnt   = !rst && m0_req && (keep0 || (!keep1 && (!m1_req || state_q == OWN1 ||
                   (state_q == IDLE && !pick1))));
        m1_gnt   = !rst && m1_req && !m0_gnt;
        bus_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
        bus_din  = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
        bus_we   = m0_gnt ? m0_we : m1_gnt && m1_we;
        acc_lock = m0_gnt ? m0_lock : m1_gnt && m1_lock;
        state_d  = acc_lock ? (m1_gnt ? OWN1 : OWN0) : IDLE;
        hold_d   = !acc_lock ? '0 : state_q == state_d ? hold_q + HW'(hold_ok) : HW'(1);
        m0_rvalid = rv0_q && !rst;
        m1_rvalid = rv1_q && !rst;
        m0_rdata  = m0_rvalid ? bus_dout : '0;
        m1_rdata  = m1_rvalid ? bus_dout : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            last_gnt_q <= 1'b0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_gnt_q <= (m0_gnt || m1_gnt) ? m1_gnt : last_gnt_q;
            rv0_q      <= m0_gnt && !m0_we;
            rv1_q      <= m1_gnt && !m1_we;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed and randomized checks of dbus_arbiter against a small bus and arbitration model.
module tb_dbus_arbiter;
    localparam int MAXH = 4;
`ifdef DBUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_we;
    logic [15:0] m0_rdata, m1_rdata, bus_addr, bus_din, bus_dout;
    logic [15:0] mem [256];
    int          vecs = 0, errs = 0;

    dbus_arbiter #(.DW(16), .AW(16), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .bus_addr(bus_addr), .bus_din(bus_din), .bus_we(bus_we), .bus_dout(bus_dout)
    );

    always #5 clk = ~clk;

    // Registered-read dbus with a fixed gpio_in value mapped at 0x2000
    always @(posedge clk) begin
        if (bus_we) mem[bus_addr[7:0]] <= bus_din;
        bus_dout <= (bus_addr == 16'h2000) ? 16'h001A : mem[bus_addr[7:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 0; m0_we = 0; m0_lock = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        m0_req = 1; m1_req = 1; m0_we = 1; m0_addr = 16'h0010; m1_addr = 16'h0020;
        for (int i = 0; i < 2; i++) begin
            #3;
            vecs++;
            if ({m1_gnt, m0_gnt} !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b want 00", {m1_gnt, m0_gnt}); end
            vecs++;
            if ({m1_rvalid, m0_rvalid} !== 2'b00) begin errs++; $display("FAIL reset_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); end
            vecs++;
            if (bus_we !== 1'b0 || bus_addr !== 16'h0) begin errs++; $display("FAIL reset_bus: got we=%b addr=%h want 0/0000", bus_we, bus_addr); end
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read;
        m0_req = 1; m0_we = 1; m0_addr = 16'h0002; m0_wdata = 16'h0032;
        #3;
        vecs++;
        if (m0_gnt !== 1'b1 || bus_we !== 1'b1) begin errs++; $display("FAIL wr_gnt: got gnt=%b we=%b want 1/1", m0_gnt, bus_we); end
        vecs++;
        if (bus_addr !== 16'h0002 || bus_din !== 16'h0032) begin errs++; $display("FAIL wr_bus: got %h/%h want 0002/0032", bus_addr, bus_din); end
        tick();
        m0_we = 0;
        #3;
        vecs++;
        if (m0_gnt !== 1'b1 || bus_we !== 1'b0 || m0_rvalid !== 1'b0) begin errs++; $display("FAIL rd_issue: got gnt=%b we=%b rv=%b want 1/0/0", m0_gnt, bus_we, m0_rvalid); end
        tick();
        m0_req = 0;
        #3;
        vecs++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h0032) begin errs++; $display("FAIL rd_data: got rv=%b data=%h want 1/0032", m0_rvalid, m0_rdata); end
        vecs++;
        if (m1_rvalid !== 1'b0) begin errs++; $display("FAIL rd_route: got m1_rvalid=%b want 0", m1_rvalid); end
        tick();
        #3;
        vecs++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h0) begin errs++; $display("FAIL rd_pulse: got rv=%b data=%h want 0/0000", m0_rvalid, m0_rdata); end
        tick();
    endtask

    task automatic test_contention;
        logic [1:0] e, prv;
        do_reset();
        prv = 2'b00;
        m0_req = 1; m1_req = 1; m0_addr = 16'h0002; m1_addr = 16'h2000;
        for (int i = 0; i < 6; i++) begin
            e = RR ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b01;
            #3;
            vecs++;
            if ({m1_gnt, m0_gnt} !== e) begin errs++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, e); end
            vecs++;
            if ({m1_rvalid, m0_rvalid} !== prv) begin errs++; $display("FAIL cont_rvalid[%0d]: got %b want %b", i, {m1_rvalid, m0_rvalid}, prv); end
            vecs++;
            if (m0_rdata !== (prv[0] ? 16'h0032 : 16'h0) || m1_rdata !== (prv[1] ? 16'h001A : 16'h0)) begin
                errs++; $display("FAIL cont_rdata[%0d]: got %h/%h for rvalid %b", i, m0_rdata, m1_rdata, prv);
            end
            prv = e;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock;
        logic [1:0] e;
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            m0_req = (i > 0);
            e = (i < MAXH) ? 2'b10 : 2'b01;
            #3;
            vecs++;
            if ({m1_gnt, m0_gnt} !== e) begin errs++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, e); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0002;
        #3;
        vecs++;
        if (m0_gnt !== 1'b1) begin errs++; $display("FAIL mid_issue: got %b want 1", m0_gnt); end
        tick();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            #3;
            vecs++;
            if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin errs++; $display("FAIL mid_rst[%0d]: got rv=%b gnt=%b want 0/0", i, m0_rvalid, m0_gnt); end
            tick();
        end
        rst = 0;
        #3;
        vecs++;
        if (m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin errs++; $display("FAIL mid_resume: got gnt=%b rv=%b want 1/0", m0_gnt, m0_rvalid); end
        tick();
        idle_inputs();
        #3;
        vecs++;
        if (m0_rvalid !== 1'b1) begin errs++; $display("FAIL mid_rvalid: got %b want 1", m0_rvalid); end
        tick();
    endtask

    task automatic test_random;
        int st, hold, a, reads, rvs;
        bit last, lk;
        logic [1:0] e, prv;
        do_reset();
        st = 0; hold = 0; last = 0; reads = 0; rvs = 0; prv = 2'b00;
        for (int n = 0; n < 10000; n++) begin
            m0_req = $urandom_range(0, 3) != 0; m1_req = $urandom_range(0, 3) != 0;
            m0_we = $urandom_range(0, 1) == 1; m1_we = $urandom_range(0, 1) == 1;
            m0_lock = $urandom_range(0, 1) == 1; m1_lock = $urandom_range(0, 2) != 0;
            m0_addr = {8'h00, 8'($urandom)}; m1_addr = {8'h00, 8'($urandom)};
            m0_wdata = 16'($urandom); m1_wdata = 16'($urandom);
            #3;
            if (st == 1 && m0_req && (!m1_req || hold < MAXH)) e = 2'b01;
            else if (st == 2 && m1_req && (!m0_req || hold < MAXH)) e = 2'b10;
            else if (m0_req && m1_req) begin
                if (st == 1) e = 2'b10;
                else if (st == 2) e = 2'b01;
                else e = (RR && !last) ? 2'b10 : 2'b01;
            end else e = {m1_req, m0_req};
            vecs++;
            if ({m1_gnt, m0_gnt} !== e) begin errs++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {m1_gnt, m0_gnt}, e); end
            vecs++;
            if ({m1_rvalid, m0_rvalid} !== prv) begin errs++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, {m1_rvalid, m0_rvalid}, prv); end
            rvs += int'(m0_rvalid === 1'b1) + int'(m1_rvalid === 1'b1);
            prv = e & {!m1_we, !m0_we};
            reads += $countones(prv);
            if (e == 2'b00) begin
                st = 0; hold = 0;
            end else begin
                a = e[1] ? 2 : 1;
                lk = e[1] ? m1_lock : m0_lock;
                last = e[1];
                if (lk) begin
                    hold = (st == a) ? ((hold < MAXH) ? hold + 1 : MAXH) : 1;
                    st = a;
                end else begin
                    st = 0; hold = 0;
                end
            end
            tick();
        end
        idle_inputs();
        #3;
        rvs += int'(m0_rvalid === 1'b1) + int'(m1_rvalid === 1'b1);
        vecs++;
        if (rvs !== reads) begin errs++; $display("FAIL rnd_count: got %0d rvalids want %0d reads", rvs, reads); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset();
        test_write_read();
        test_contention();
        test_lock();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
